bram_stream_reader: RTL and testbench

Burst reader that fetches a programmable run of words from a single-port view of a true dual-port BRAM and presents them on a valid/ready stream. It replaces the fixed-count, start-at-zero reader with a generalised engine: programmable base address and length, back-pressure tolerance through a 2-entry skid FIFO that hides the 1-cycle BRAM read latency, and configurable address wrap. It sits between the control sequencer (start/idle/run/done) and any downstream consumer of BRAM contents. It drives BRAM port 0 only; port 1 stays free for a writer.

---
 rtl/bram_stream_reader_if.sv | 10 +
 rtl/bram_stream_reader.sv | 88 ++++++++
 tb/tb_bram_stream_reader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: valid/ready word stream between the reader and its consumer.
interface bram_stream_reader_if #(
   parameter int DWIDTH = 32
) ();
   logic              valid;
   logic              ready;
   logic [DWIDTH-1:0] data;
   modport master (output valid, data, input ready);
   modport slave (input valid, data, output ready);
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: programmable base/length BRAM burst reader with a 2-entry skid FIFO on a valid/ready stream.
// Define BRAM_READER_WRAP_EN to wrap the read address from MEM_SIZE-1 back to 0 instead of ending the burst there.
module bram_stream_reader #(
   parameter int DWIDTH   = 32,
   parameter int AWIDTH   = 7,
   parameter int MEM_SIZE = 100,
   parameter int LWIDTH   = AWIDTH + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [AWIDTH-1:0] base_addr_i,
   input  logic [LWIDTH-1:0] len_i,
   output logic              idle_o,
   output logic              run_o,
   output logic              done_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   input  logic [DWIDTH-1:0] mem_q_i,
   bram_stream_reader_if.master m
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam logic [AWIDTH-1:0] LAST = AWIDTH'(MEM_SIZE - 1);
   state_t state, state_n;
   logic [AWIDTH-1:0] addr, addr_nx;
   logic [LWIDTH-1:0] issued, len_q;
   logic [1:0] count, count_n;
   logic [DWIDTH-1:0] d0, d1;
   logic inflight, pop, issue, addr_ok, at_last, stop;
   assign pop = m.valid & m.ready;
   // occupancy after this cycle: buffered words plus the read landing now, minus the pop
   assign count_n = count + {1'b0, inflight} - {1'b0, pop};
   assign at_last = addr == LAST;
`ifdef BRAM_READER_WRAP_EN
   assign addr_ok = 1'b1;
   assign stop = 1'b0;
   assign addr_nx = at_last ? '0 : addr + 1'b1;
`else
   localparam logic [AWIDTH:0] MEM_LIM = (AWIDTH + 1)'(MEM_SIZE);
   assign addr_ok = {1'b0, addr} < MEM_LIM;
   assign stop = at_last;
   assign addr_nx = addr + 1'b1;
`endif
   assign issue = state == RUN && addr_ok && issued < len_q && count_n < 2'd2;
   assign m.valid = count != 2'd0;
   assign m.data = d0;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb
      state_n = state == IDLE  ? (start_i ? (len_i == '0 ? DONE : RUN) : IDLE) :
                state == RUN   ? ((!addr_ok || (issue && (issued + 1'b1 == len_q || stop))) ? DRAIN : RUN) :
                state == DRAIN ? (count_n == 2'd0 ? DONE : DRAIN) : IDLE;
   always_comb begin
      idle_o = state == IDLE;
      run_o = state == RUN || state == DRAIN;
      done_o = state == DONE;
      mem_ce_o = issue;
      mem_addr_o = addr;
      mem_we_o = 1'b0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         addr <= '0;
         issued <= '0;
         len_q <= '0;
         count <= '0;
         inflight <= 1'b0;
         d0 <= '0;
         d1 <= '0;
      end else begin
         inflight <= issue;
         count <= count_n;
         if (state == IDLE && start_i) begin
            addr <= base_addr_i;
            issued <= '0;
            len_q <= len_i;
         end else if (issue) begin
            addr <= addr_nx;
            issued <= issued + 1'b1;
         end
         // head is refilled from the second slot on pop, or straight from BRAM when it would be empty
         if (pop && count == 2'd2) d0 <= d1;
         else if (inflight && count_n == 2'd1) d0 <= mem_q_i;
         if (inflight && count == 2'd1 && !pop) d1 <= mem_q_i;
      end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: table-driven and randomized bursts checked against a queue-based reference model.
module tb_bram_stream_reader;
   localparam int DW = 32, AW = 7, MS = 100, LW = 8;
`ifdef BRAM_READER_WRAP_EN
   localparam bit WR = 1'b1;
`else
   localparam bit WR = 1'b0;
`endif
   typedef struct {int base; int len; int mode; int words; int done_cyc;} vec_t;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [AW-1:0] base = '0;
   logic [LW-1:0] len = '0;
   logic idle, run, done, ce, we;
   logic [AW-1:0] addr;
   logic [DW-1:0] q;
   logic [DW-1:0] mem [0:127];
   int errors = 0, checks = 0;
   vec_t tbl [10];
   bram_stream_reader_if #(.DWIDTH(DW)) s ();
   bram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .LWIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base), .len_i(len),
      .idle_o(idle), .run_o(run), .done_o(done), .mem_addr_o(addr), .mem_ce_o(ce),
      .mem_we_o(we), .mem_q_i(q), .m(s)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (ce) q <= mem[addr];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic reset_vals(input string tag);
      chk({tag, "_idle"}, idle, 1);
      chk({tag, "_run"}, run, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ce"}, ce, 0);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_valid"}, s.valid, 0);
      chk({tag, "_data"}, s.data, 0);
   endtask
   // mode: 0 ready high, 1 pattern 1,0,0,1,0,1, 2 random, 3 mostly stalled
   task automatic burst(input int b, input int l, input int mode, input int exp_words, input int exp_done, input bit poke);
      int exp_addr[$];
      logic [DW-1:0] exp_q[$];
      int outstanding = 0, got = 0, dcyc = -1, first_ce = -1, nexp;
      logic [5:0] pat = 6'b101001;
      for (int k = 0; k < l; k++) begin
         int a;
         a = b + k;
         if (WR) a = a % MS;
         else if (a >= MS) break;
         exp_addr.push_back(a);
         exp_q.push_back(mem[a]);
      end
      nexp = exp_q.size();
      @(posedge clk); #1;
      start = 1'b1; base = AW'(b); len = LW'(l); s.ready = 1'b1;
      @(negedge clk);
      chk("idle_at_start", idle, 1);
      for (int cyc = 1; cyc <= 2000 && dcyc < 0; cyc++) begin
         @(posedge clk); #1;
         start = poke && cyc == 2;
         if (poke) begin base = AW'(50); len = LW'(1); end
         s.ready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 6] :
                   mode == 2 ? 1'($urandom % 2) : 1'($urandom % 4 == 0);
         @(negedge clk);
         if (ce) begin
            if (first_ce < 0) first_ce = cyc;
            chk("issue_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) chk("issue_addr", addr, exp_addr.pop_front());
            chk("issue_while_full", outstanding == 2 && !(s.valid && s.ready), 0);
            outstanding++;
         end
         if (s.valid && s.ready) begin
            chk("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("data", s.data, exp_q.pop_front());
            outstanding--;
            got++;
         end
         if (outstanding > 2) chk("buffered", outstanding, 2);
         if (!done && l > 0) chk("run_high", run, 1);
         if (done) dcyc = cyc;
      end
      chk("done_seen", dcyc >= 0, 1);
      chk("words_model", got, nexp);
      if (exp_words >= 0) chk("words_table", got, exp_words);
      if (exp_done >= 0) chk("done_cycle", dcyc, exp_done);
      if (exp_done >= 0 && nexp > 0) chk("first_issue_cycle", first_ce, 1);
      @(posedge clk); #1;
      start = 1'b0; s.ready = 1'b1;
      @(negedge clk);
      chk("done_single", done, 0);
      chk("idle_after", idle, 1);
      chk("no_issue_after", ce, 0);
      chk("we_low", we, 0);
   endtask
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = DW'(i + 100);
      s.ready = 1'b1;
      tbl[0] = '{5, 4, 0, 4, 7};
      tbl[1] = '{5, 4, 1, 4, -1};
      tbl[2] = '{0, 0, 0, 0, 1};
      tbl[3] = '{0, 1, 0, 1, 4};
      tbl[4] = '{98, 4, 0, WR ? 4 : 2, WR ? 7 : 5};
      tbl[5] = '{99, 1, 0, 1, 4};
      tbl[6] = '{0, 100, 0, 100, 103};
      tbl[7] = '{20, 10, 1, 10, -1};
      tbl[8] = '{60, 50, 0, WR ? 50 : 40, WR ? 53 : 43};
      tbl[9] = '{90, 30, 3, WR ? 30 : 10, -1};
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_vals("reset");
      @(posedge clk); #1 rst = 1'b0;
      foreach (tbl[i]) burst(tbl[i].base, tbl[i].len, tbl[i].mode, tbl[i].words, tbl[i].done_cyc, 1'b0);
      burst(5, 4, 0, 4, 7, 1'b1);
      // reset while words sit in the skid buffer under back-pressure
      @(posedge clk); #1;
      start = 1'b1; base = AW'(10); len = LW'(20); s.ready = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("buffered_before_reset", s.valid, 1);
      @(posedge clk); #1 rst = 1'b1;
      #1 reset_vals("async_reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; s.ready = 1'b1;
      burst(5, 4, 0, 4, 7, 1'b0);
      for (int i = 0; i < 30; i++)
         burst(int'($urandom_range(MS - 1, 0)), int'($urandom_range(130, 0)), 2 + int'($urandom % 2), -1, -1, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
